// File: rtl/chess_board_controller.sv
// chess_board_controller
//   Board-state stage of the chess display pipeline. The four direction
//   pushbuttons and the lock switch are synchronised and debounced. The
//   buttons move a board cursor. The lock switch picks up and drops pieces
//   in a 64-square board store, which is presented as a packed matrix.
//
// Ports
//   clock        system clock
//   resetApp     asynchronous, active-high reset
//   gameEnable   0 = key/lock events discarded, board frozen
//   KeyLeft/KeyRight/KeyUp/KeyDown  raw pushbuttons, active-low, async
//   LockSwitch   raw slide switch, async; on = pick up, off = drop
//   Matrix       square s at [4s+3:4s]: [2:0] piece code, [3] colour
//   cursorIdx    cursor square, row*8+col
//   heldIdx      source square of the held piece
//   holding      a piece is picked up
//   turn         side to move, 1 = light, 0 = dark
//   moveDone     one-cycle pulse on a completed move
//   dbg_state_o  current FSM state (IDLE=0, HELD=1, REJECT=2)
//
// Handshake note: there are no valid/ready channels here. All inputs are
// levels and every output is a register updated on the rising clock edge.
module chess_board_controller #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18
) (
    input  logic         clock,
    input  logic         resetApp,
    input  logic         gameEnable,
    input  logic         KeyLeft,
    input  logic         KeyRight,
    input  logic         KeyUp,
    input  logic         KeyDown,
    input  logic         LockSwitch,
    output logic [255:0] Matrix,
    output logic [5:0]   cursorIdx,
    output logic [5:0]   heldIdx,
    output logic         holding,
    output logic         turn,
    output logic         moveDone,
    output logic [1:0]   dbg_state_o
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REJECT = 2'd2
    } state_t;

    // Input lanes: 0 left, 1 right, 2 up, 3 down, 4 lock.
    localparam int NIN = 5;
    // Keys idle released (1) and the lock idles off (0).
    localparam logic [NIN-1:0] ACC_RESET = 5'b01111;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    function automatic logic [255:0] reset_layout();
        logic [255:0] b;
        logic [23:0]  back;
        b    = '0;
        // Back rank listed from col 7 down to col 0.
        back = {3'd5, 3'd4, 3'd3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        for (int c = 0; c < 8; c++) begin
            b[4*c +: 4]      = {1'b0, back[3*c +: 3]};
            b[4*(8+c) +: 4]  = 4'h6;
            b[4*(48+c) +: 4] = 4'hE;
            b[4*(56+c) +: 4] = {1'b1, back[3*c +: 3]};
        end
        return b;
    endfunction

    localparam logic [255:0] RESET_LAYOUT = reset_layout();

    logic [NIN-1:0]       raw_in;
    logic [NIN-1:0]       sync1_q, sync2_q, acc_q, rise_q, fall_q;
    logic [CNT_WIDTH-1:0] cnt_q [NIN];

    assign raw_in = {LockSwitch, KeyDown, KeyUp, KeyRight, KeyLeft};

    // Synchroniser + debouncer. The accepted level flips only after
    // DEBOUNCE_CYCLES consecutive synchronised samples that disagree with it.
    // rise_q/fall_q are one-cycle registered pulses for the accepted edges.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            sync1_q <= ACC_RESET;
            sync2_q <= ACC_RESET;
            acc_q   <= ACC_RESET;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < NIN; i++) begin
                if (sync2_q[i] != acc_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        acc_q[i]  <= sync2_q[i];
                        cnt_q[i]  <= '0;
                        rise_q[i] <= sync2_q[i];
                        fall_q[i] <= ~sync2_q[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Events are consumed regardless of gameEnable; they only act when enabled.
    logic [3:0] key_ev;
    logic       lock_on, lock_off;
    assign key_ev   = gameEnable ? fall_q[3:0] : 4'b0000;
    assign lock_on  = gameEnable & rise_q[4];
    assign lock_off = gameEnable & fall_q[4];

    state_t       state_q;
    logic [255:0] board_q;
    logic [5:0]   cursor_q, cursor_d, held_q;
    logic         holding_q, turn_q, move_done_q;
    logic [3:0]   cur_sq, held_sq;

    assign cur_sq  = board_q[{cursor_q, 2'b00} +: 4];
    assign held_sq = board_q[{held_q, 2'b00} +: 4];

    // Saturating cursor step; only the highest-priority press acts.
    always_comb begin
        cursor_d = cursor_q;
        if (key_ev[0]) begin
            if (cursor_q[2:0] != 3'd0) cursor_d[2:0] = cursor_q[2:0] - 3'd1;
        end else if (key_ev[1]) begin
            if (cursor_q[2:0] != 3'd7) cursor_d[2:0] = cursor_q[2:0] + 3'd1;
        end else if (key_ev[2]) begin
            if (cursor_q[5:3] != 3'd0) cursor_d[5:3] = cursor_q[5:3] - 3'd1;
        end else if (key_ev[3]) begin
            if (cursor_q[5:3] != 3'd7) cursor_d[5:3] = cursor_q[5:3] + 3'd1;
        end
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q     <= ST_IDLE;
            board_q     <= RESET_LAYOUT;
            cursor_q    <= '0;
            held_q      <= '0;
            holding_q   <= 1'b0;
            turn_q      <= 1'b1;
            move_done_q <= 1'b0;
        end else begin
            cursor_q    <= cursor_d;
            move_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lock_on) begin
                        if (cur_sq[2:0] != 3'd0 && cur_sq[3] == turn_q) begin
                            state_q   <= ST_HELD;
                            held_q    <= cursor_q;
                            holding_q <= 1'b1;
                        end else begin
                            state_q <= ST_REJECT;
                        end
                    end
                end
                ST_HELD: begin
                    if (lock_off) begin
                        state_q   <= ST_IDLE;
                        holding_q <= 1'b0;
                        // Dropping on the source or on an own piece cancels.
                        if (!(cursor_q == held_q ||
                              (cur_sq[2:0] != 3'd0 && cur_sq[3] == turn_q))) begin
                            board_q[{cursor_q, 2'b00} +: 4] <= held_sq;
                            board_q[{held_q, 2'b00} +: 4]   <= 4'h0;
                            turn_q      <= ~turn_q;
                            move_done_q <= 1'b1;
                        end
                    end
                end
                ST_REJECT: begin
                    if (lock_off) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Matrix      = board_q;
    assign cursorIdx   = cursor_q;
    assign heldIdx     = held_q;
    assign holding     = holding_q;
    assign turn        = turn_q;
    assign moveDone    = move_done_q;
    assign dbg_state_o = state_q;
endmodule
